// File: rtl/comp_thresh_shifter_pkg.sv
// -----------------------------------------------------------------------------
// comp_thresh_shifter_pkg
// Shared constants and types for the comparator-threshold serial path.
// The load FSM imports the same package so both sides agree on the word
// width, the counter width, the terminal count and the chip-select idle level.
// -----------------------------------------------------------------------------
package comp_thresh_shifter_pkg;

    // Default threshold word width and bit-counter width (WIDTH == 2**CNT_W)
    localparam int WIDTH_DEF = 16;
    localparam int CNT_W_DEF = 4;

    // Counter value of the final bit of a frame
    localparam logic [CNT_W_DEF-1:0] CNT_TERM = 4'(WIDTH_DEF - 1);

    // Level of DAC_CS_N outside a frame
    localparam logic CS_N_IDLE = 1'b1;

    // Bit-cell phase: SETUP holds SCLK low, HIGH drives the SCLK pulse
    typedef enum logic {
        PH_SETUP = 1'b0,
        PH_HIGH  = 1'b1
    } phase_e;

endpackage : comp_thresh_shifter_pkg

// File: rtl/comp_thresh_shifter_if.sv
// -----------------------------------------------------------------------------
// comp_thresh_shifter_if
// Bundle between the threshold load FSM (master) and the serialiser (slave).
//   CLR_CNT, SHFT_ENA, SET_DONE : strobes/levels from the FSM
//   THRESH_DATA                 : parallel threshold word
//   CNT                         : completed-bit count back to the FSM
//   DAC_DIN/DAC_SCLK/DAC_CS_N   : DAC serial interface
//   BUSY, DONE                  : frame-in-progress and sticky completion
// -----------------------------------------------------------------------------
interface comp_thresh_shifter_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
);
    logic             CLR_CNT;
    logic             SHFT_ENA;
    logic             SET_DONE;
    logic [WIDTH-1:0] THRESH_DATA;
    logic [CNT_W-1:0] CNT;
    logic             DAC_DIN;
    logic             DAC_SCLK;
    logic             DAC_CS_N;
    logic             BUSY;
    logic             DONE;

    modport master (
        output CLR_CNT, SHFT_ENA, SET_DONE, THRESH_DATA,
        input  CNT, DAC_DIN, DAC_SCLK, DAC_CS_N, BUSY, DONE
    );

    modport slave (
        input  CLR_CNT, SHFT_ENA, SET_DONE, THRESH_DATA,
        output CNT, DAC_DIN, DAC_SCLK, DAC_CS_N, BUSY, DONE
    );
endinterface : comp_thresh_shifter_if

// File: rtl/comp_thresh_bitcell.sv
// -----------------------------------------------------------------------------
// comp_thresh_bitcell
// Two-phase bit-cell generator. Each bit takes two CLK cycles: a SETUP cycle
// with SCLK low, then a HIGH cycle with SCLK high. A HIGH cycle always
// finishes, so SCLK pulses are never truncated.
// Ports:
//   CLK, RST   : clock, synchronous active-high reset
//   load       : frame restart, forces SETUP with SCLK low
//   busy       : a frame is in progress
//   shft_ena   : shift enable level from the FSM
//   cnt_last   : counter is on the final bit (drain even without shft_ena)
//   sclk       : registered serial clock
//   bit_done   : high during the HIGH phase; the bit completes at its end
// -----------------------------------------------------------------------------
module comp_thresh_bitcell
    import comp_thresh_shifter_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic load,
    input  logic busy,
    input  logic shft_ena,
    input  logic cnt_last,
    output logic sclk,
    output logic bit_done
);

    phase_e ph_r;
    phase_e ph_nxt_s;
    logic   sclk_r;
    logic   sclk_nxt_s;

    // Phase and SCLK state registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            ph_r   <= PH_SETUP;
            sclk_r <= 1'b0;
        end else begin
            ph_r   <= ph_nxt_s;
            sclk_r <= sclk_nxt_s;
        end
    end

    // Next phase: SETUP advances when shifting is active, HIGH always returns
    always_comb begin
        ph_nxt_s   = ph_r;
        sclk_nxt_s = sclk_r;
        if (load) begin
            ph_nxt_s   = PH_SETUP;
            sclk_nxt_s = 1'b0;
        end else begin
            case (ph_r)
                PH_SETUP: begin
                    // Final bit drains even if the FSM already dropped shft_ena
                    if (busy && (shft_ena || cnt_last)) begin
                        ph_nxt_s   = PH_HIGH;
                        sclk_nxt_s = 1'b1;
                    end else begin
                        ph_nxt_s   = PH_SETUP;
                        sclk_nxt_s = 1'b0;
                    end
                end
                PH_HIGH: begin
                    ph_nxt_s   = PH_SETUP;
                    sclk_nxt_s = 1'b0;
                end
                default: begin
                    ph_nxt_s   = PH_SETUP;
                    sclk_nxt_s = 1'b0;
                end
            endcase
        end
    end

    assign sclk     = sclk_r;
    assign bit_done = (ph_r == PH_HIGH);

endmodule : comp_thresh_bitcell

// File: rtl/comp_thresh_shifter.sv
// -----------------------------------------------------------------------------
// comp_thresh_shifter
// Serialises a WIDTH-bit threshold word MSB-first onto the comparator DAC
// interface under control of the threshold load FSM.
// Ports:
//   CLK  : system clock, rising edge
//   RST  : synchronous active-high reset, aborts any frame immediately
//   bus  : slave side of comp_thresh_shifter_if (FSM strobes, THRESH_DATA,
//          CNT feedback, DAC_DIN/DAC_SCLK/DAC_CS_N, BUSY, DONE)
// A load (CLR_CNT) wins over everything else and restarts the frame. Each
// bit is two cycles; DIN changes only on the SCLK falling cycle, so it is
// stable one cycle either side of each SCLK rising edge.
// -----------------------------------------------------------------------------
module comp_thresh_shifter
    import comp_thresh_shifter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    comp_thresh_shifter_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // The MSB is presented on DIN at load, so the register only keeps the
    // remaining WIDTH-1 bits; its top bit is always the next DIN value.
    logic [WIDTH-2:0] sr_r;
    logic [CNT_W-1:0] cnt_r;
    logic             din_r;
    logic             cs_n_r;
    logic             busy_r;
    logic             done_r;
    logic             sclk_s;
    logic             bit_done_s;
    logic             cnt_last_s;

    assign cnt_last_s = (cnt_r == CNT_LAST);

    comp_thresh_bitcell u_bitcell (
        .CLK      (CLK),
        .RST      (RST),
        .load     (bus.CLR_CNT),
        .busy     (busy_r),
        .shft_ena (bus.SHFT_ENA),
        .cnt_last (cnt_last_s),
        .sclk     (sclk_s),
        .bit_done (bit_done_s)
    );

    // Shift register, bit counter, chip select, busy and done flags
    always_ff @(posedge CLK) begin
        if (RST) begin
            sr_r   <= '0;
            cnt_r  <= '0;
            din_r  <= 1'b0;
            cs_n_r <= CS_N_IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (bus.CLR_CNT) begin
            sr_r   <= bus.THRESH_DATA[WIDTH-2:0];
            cnt_r  <= '0;
            din_r  <= bus.THRESH_DATA[WIDTH-1];
            cs_n_r <= ~CS_N_IDLE;
            busy_r <= 1'b1;
            done_r <= 1'b0;
        end else begin
            if (bit_done_s) begin
                sr_r  <= {sr_r[WIDTH-3:0], 1'b0};
                cnt_r <= cnt_r + CNT_W'(1);
                if (cnt_last_s) begin
                    // Final bit: close the frame, counter wraps to 0
                    din_r  <= 1'b0;
                    cs_n_r <= CS_N_IDLE;
                    busy_r <= 1'b0;
                end else begin
                    din_r  <= sr_r[WIDTH-2];
                end
            end
            if (bus.SET_DONE) begin
                done_r <= 1'b1;
            end
        end
    end

    assign bus.CNT      = cnt_r;
    assign bus.DAC_DIN  = din_r;
    assign bus.DAC_SCLK = sclk_s;
    assign bus.DAC_CS_N = cs_n_r;
    assign bus.BUSY     = busy_r;
    assign bus.DONE     = done_r;

endmodule : comp_thresh_shifter
